// File: rtl/reg_load_pkg.sv
// rtl/reg_load_pkg.sv - shared encodings and defaults for the regLoad sequencer
//
// Purpose: state encoding, regLoad select codes and default geometry used by
//          reg_load_ctrl, reg_load_reg, reg_load_frame and reg_load_ctrl_if.
// Ports:   none (package).
package reg_load_pkg;

    localparam int WIDTH_DEF = 3;   // bits per element
    localparam int N_DEF     = 2;   // elements per half-frame
    localparam int CNT_W_DEF = 8;   // completed-frame counter width

    typedef logic [1:0] state_t;
    typedef logic [1:0] load_t;

    localparam state_t S_LO   = 2'd0;
    localparam state_t S_HI   = 2'd1;
    localparam state_t S_FULL = 2'd2;

    localparam load_t LOAD_NONE = 2'b00;
    localparam load_t LOAD_LO   = 2'b01;
    localparam load_t LOAD_HI   = 2'b10;

    function automatic int half_bits(input int width, input int n);
        return width * n;
    endfunction

endpackage

// File: rtl/reg_load_ctrl_if.sv
// rtl/reg_load_ctrl_if.sv - half-frame input, regLoad drive and frame output bundle
//
// Purpose: groups the upstream handshake, flush, regLoad select/data and the
//          merge-side handshake plus status.
// Ports:   slave  - seen by the controller (in_valid/in_data/flush/out_ready in)
//          master - seen by the upstream source / merge stage
interface reg_load_ctrl_if #(
    parameter int WIDTH = reg_load_pkg::WIDTH_DEF,
    parameter int N     = reg_load_pkg::N_DEF,
    parameter int CNT_W = reg_load_pkg::CNT_W_DEF
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [N*WIDTH-1:0]       in_data;
    logic                     flush;
    logic [1:0]               load;
    logic [2*N*WIDTH-1:0]     inba;
    logic                     out_valid;
    logic                     out_ready;
    logic [CNT_W-1:0]         frame_cnt;
    logic                     busy;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, load, inba, out_valid, frame_cnt, busy
    );

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, load, inba, out_valid, frame_cnt, busy
    );

endinterface

// File: rtl/reg_load_frame.sv
// rtl/reg_load_frame.sv - controller plus regLoad, exposing y to the merge stage
//
// Purpose: integration wrapper tying reg_load_ctrl to the regLoad register.
// Ports:   clk - system clock
//          rst - asynchronous active-high reset
//          bus - reg_load_ctrl_if.slave
//          y   - full 2N-element frame, valid while bus.out_valid is high
module reg_load_frame
    import reg_load_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_load_ctrl_if.slave       bus,
    output logic [2*N*WIDTH-1:0] y
);

    reg_load_ctrl #(
        .WIDTH (WIDTH),
        .N     (N),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    reg_load_reg #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_reg (
        .clk  (clk),
        .load (bus.load),
        .inba (bus.inba),
        .y    (y)
    );

endmodule

// File: rtl/reg_load_reg.sv
// rtl/reg_load_reg.sv - regLoad half-word register
//
// Purpose: 2N-element register written one half at a time by the load select.
// Ports:   clk  - system clock
//          load - 01 writes lower half, 10 writes upper half, else hold
//          inba - {in_data, in_data}; each half is taken from its own lane
//          y    - full frame {upper, lower} presented to the merge stage
module reg_load_reg
    import reg_load_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N     = N_DEF
) (
    input  logic                 clk,
    input  logic [1:0]           load,
    input  logic [2*N*WIDTH-1:0] inba,
    output logic [2*N*WIDTH-1:0] y
);

    localparam int HALF_W = half_bits(WIDTH, N);

    // Data register only: after a reset the content is stale but the
    // controller never presents it until both halves are rewritten.
    always_ff @(posedge clk) begin
        case (load)
            LOAD_LO: y[HALF_W-1:0]        <= inba[HALF_W-1:0];
            LOAD_HI: y[2*HALF_W-1:HALF_W] <= inba[2*HALF_W-1:HALF_W];
            default: y                    <= y;
        endcase
    end

endmodule

// File: rtl/reg_load_ctrl.sv
// rtl/reg_load_ctrl.sv - sequencer loading half-frames into regLoad
//
// Purpose: accepts lower then upper half-frames, drives regLoad's select and
//          data bus, and hands the completed frame to the merge stage.
// Ports:   clk - system clock, rising edge
//          rst - asynchronous active-high reset
//          bus - reg_load_ctrl_if.slave (handshakes, flush, load, inba,
//                out_valid, frame_cnt, busy)
module reg_load_ctrl
    import reg_load_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    reg_load_ctrl_if.slave bus
);

    localparam int HALF_W = half_bits(WIDTH, N);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        load_c;
    logic              in_ready_c;
    logic              hand_off;
    logic              out_valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [HALF_W-1:0] half;

    // Select and ready are combinational so regLoad captures on the same
    // edge as the accepting handshake.
    always_comb begin
        state_nxt  = state;
        load_c     = LOAD_NONE;
        in_ready_c = 1'b0;
        hand_off   = 1'b0;
        if (!rst) begin
            case (state)
                S_LO: begin
                    in_ready_c = 1'b1;
                    if (bus.in_valid) begin
                        load_c    = LOAD_LO;
                        state_nxt = S_HI;
                    end
                end
                S_HI: begin
                    // Flush beats a simultaneous upper half: nothing loads.
                    if (bus.flush) begin
                        state_nxt = S_LO;
                    end else begin
                        in_ready_c = 1'b1;
                        if (bus.in_valid) begin
                            load_c    = LOAD_HI;
                            state_nxt = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    // Overwriting the lower half is safe only on the edge the
                    // consumer takes the old frame, so ready follows out_ready.
                    in_ready_c = bus.out_ready;
                    if (bus.out_ready) begin
                        hand_off = 1'b1;
                        if (bus.in_valid) begin
                            load_c    = LOAD_LO;
                            state_nxt = S_HI;
                        end else begin
                            state_nxt = S_LO;
                        end
                    end
                end
                default: state_nxt = S_LO;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_LO;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state       <= state_nxt;
            out_valid_q <= (state_nxt == S_FULL);
            if (hand_off) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign half          = bus.in_data;
    assign bus.inba      = {half, half};
    assign bus.load      = load_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_cnt = cnt_q;
    assign bus.busy      = (state != S_LO);

endmodule

// File: tb/tb_reg_load_ctrl.sv
// tb/tb_reg_load_ctrl.sv - self-checking bench for reg_load_ctrl with regLoad
module tb_reg_load_ctrl;

    localparam int W  = 3;
    localparam int N  = 2;
    localparam int HW = W * N;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*HW-1:0] y;

    always #5 clk = ~clk;

    reg_load_ctrl_if #(.WIDTH(W), .N(N), .CNT_W(8)) bus ();
    reg_load_ctrl_if #(.WIDTH(W), .N(N), .CNT_W(2)) bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_data   = bus.in_data;
    assign bus2.flush     = bus.flush;
    assign bus2.out_ready = bus.out_ready;

    reg_load_ctrl #(.WIDTH(W), .N(N), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    reg_load_reg #(.WIDTH(W), .N(N)) u_reg (
        .clk  (clk),
        .load (bus.load),
        .inba (bus.inba),
        .y    (y)
    );

    reg_load_ctrl #(.WIDTH(W), .N(N), .CNT_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int total;
    int bad;

    // Reference model: which halves are held and the frame contents.
    bit          m_lo;
    bit          m_full;
    logic [HW-1:0] m_y_lo;
    logic [HW-1:0] m_y_hi;
    int          m_cnt;
    logic        exp_ready;
    logic [1:0]  exp_load;

    logic          d_iv;
    logic [HW-1:0] d_d;
    logic          d_fl;
    logic          d_or;

    // Apply inputs away from the active edge and compute expected comb outputs.
    task automatic drive(input logic r, input logic iv, input logic [HW-1:0] d,
                         input logic fl, input logic orr);
        @(negedge clk);
        rst = r; bus.in_valid = iv; bus.in_data = d; bus.flush = fl; bus.out_ready = orr;
        d_iv = iv; d_d = d; d_fl = fl; d_or = orr;
        if (r) begin m_lo = 1'b0; m_full = 1'b0; m_cnt = 0; end
        #1;
        if (r) begin
            exp_ready = 1'b0; exp_load = 2'b00;
        end else if (m_full) begin
            exp_ready = orr; exp_load = (orr && iv) ? 2'b01 : 2'b00;
        end else if (m_lo) begin
            exp_ready = !fl; exp_load = (!fl && iv) ? 2'b10 : 2'b00;
        end else begin
            exp_ready = 1'b1; exp_load = iv ? 2'b01 : 2'b00;
        end
    endtask

    // Advance the model across the rising edge.
    task automatic commit();
        @(posedge clk);
        if (!rst) begin
            if (exp_load == 2'b01) m_y_lo = d_d;
            if (exp_load == 2'b10) m_y_hi = d_d;
            if (m_full) begin
                if (d_or) begin m_cnt++; m_full = 1'b0; m_lo = d_iv; end
            end else if (m_lo) begin
                if (d_fl) m_lo = 1'b0;
                else if (d_iv) begin m_lo = 1'b0; m_full = 1'b1; end
            end else begin
                m_lo = d_iv;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, '0, 0, 0);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.load !== 2'b00) begin bad++; $display("FAIL reset_load got=%b want=00", bus.load); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", bus.frame_cnt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        commit();
    endtask

    task automatic test_basic();
        drive(0, 1, 6'd5, 0, 1);
        total++; if (bus.load !== 2'b01) begin bad++; $display("FAIL basic_load_lo got=%b want=01", bus.load); end
        total++; if (bus.inba !== {6'd5, 6'd5}) begin bad++; $display("FAIL basic_inba got=%h want=%h", bus.inba, {6'd5, 6'd5}); end
        commit();
        drive(0, 1, 6'd2, 0, 1);
        total++; if (bus.load !== 2'b10) begin bad++; $display("FAIL basic_load_hi got=%b want=10", bus.load); end
        commit();
        drive(0, 0, '0, 0, 1);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b want=1", bus.out_valid); end
        total++; if (y !== {6'd2, 6'd5}) begin bad++; $display("FAIL basic_y got=%h want=%h", y, {6'd2, 6'd5}); end
        commit();
        drive(0, 0, '0, 0, 0);
        total++; if (bus.frame_cnt !== 8'd1) begin bad++; $display("FAIL basic_frame_cnt got=%0d want=1", bus.frame_cnt); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_out_valid_drop got=%b want=0", bus.out_valid); end
        commit();
    endtask

    task automatic test_hold();
        drive(0, 1, 6'd5, 0, 0); commit();
        drive(0, 1, 6'd2, 0, 0); commit();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 6'd7, 0, 0);
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL hold_out_valid[%0d] got=%b want=1", i, bus.out_valid); end
            total++; if (bus.load !== 2'b00) begin bad++; $display("FAIL hold_load[%0d] got=%b want=00", i, bus.load); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d] got=%b want=0", i, bus.in_ready); end
            commit();
            total++; if (y !== {6'd2, 6'd5}) begin bad++; $display("FAIL hold_y[%0d] got=%h want=%h", i, y, {6'd2, 6'd5}); end
        end
        drive(0, 0, '0, 0, 1); commit();
        drive(0, 0, '0, 0, 0);
        total++; if (bus.frame_cnt !== 8'd2) begin bad++; $display("FAIL hold_frame_cnt got=%0d want=2", bus.frame_cnt); end
        commit();
    endtask

    task automatic test_back_to_back();
        logic [HW-1:0] hi_v;
        logic [HW-1:0] lo_v;
        for (int k = 1; k <= 6; k++) begin
            drive(0, 1, HW'(k), 0, 1);
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%b want=1", k, bus.in_ready); end
            total++; if (bus.load !== ((k % 2) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL b2b_load[%0d] got=%b want=%b", k, bus.load, (k % 2) ? 2'b01 : 2'b10); end
            if (k == 3 || k == 5) begin
                hi_v = HW'(k - 1); lo_v = HW'(k - 2);
                total++; if (y !== {hi_v, lo_v} || bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_frame[%0d] got=%h/%b want=%h/1", k, y, bus.out_valid, {hi_v, lo_v}); end
            end
            commit();
        end
        drive(0, 0, '0, 0, 1);
        total++; if (y !== {6'd6, 6'd5} || bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_last got=%h/%b want=%h/1", y, bus.out_valid, {6'd6, 6'd5}); end
        commit();
        drive(0, 0, '0, 0, 0);
        total++; if (bus.frame_cnt !== 8'd5) begin bad++; $display("FAIL b2b_frame_cnt got=%0d want=5", bus.frame_cnt); end
        commit();
    endtask

    task automatic test_flush();
        drive(0, 1, 6'd7, 0, 1); commit();
        drive(0, 1, 6'd3, 1, 1);
        total++; if (bus.load !== 2'b00) begin bad++; $display("FAIL flush_load got=%b want=00", bus.load); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", bus.in_ready); end
        commit();
        drive(0, 0, '0, 0, 1);
        total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_idle got=busy%b/ov%b want=0/0", bus.busy, bus.out_valid); end
        commit();
        drive(0, 1, 6'd4, 1, 1);
        total++; if (bus.load !== 2'b01) begin bad++; $display("FAIL flush_ignored_lo got=%b want=01", bus.load); end
        commit();
        drive(0, 1, 6'd1, 0, 1); commit();
        drive(0, 0, '0, 1, 0);
        total++; if (y !== {6'd1, 6'd4} || bus.out_valid !== 1'b1) begin bad++; $display("FAIL flush_y got=%h/%b want=%h/1", y, bus.out_valid, {6'd1, 6'd4}); end
        commit();
        drive(0, 0, '0, 0, 1);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL flush_ignored_full got=%b want=1", bus.out_valid); end
        commit();
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 6'd6, 0, 1); commit();
        drive(1, 0, '0, 0, 1);
        total++; if (bus.out_valid !== 1'b0 || bus.frame_cnt !== 8'd0 || bus.load !== 2'b00) begin bad++; $display("FAIL rstmid_state got=ov%b cnt%0d load%b want=0/0/00", bus.out_valid, bus.frame_cnt, bus.load); end
        commit();
        drive(0, 1, 6'd3, 0, 1);
        total++; if (bus.load !== 2'b01) begin bad++; $display("FAIL rstmid_load got=%b want=01", bus.load); end
        commit();
        drive(0, 0, '0, 0, 1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_frame got=%b want=0", bus.out_valid); end
        commit();
    endtask

    task automatic test_wrap();
        int seq [5] = '{1, 2, 3, 0, 1};
        drive(1, 0, '0, 0, 0); commit();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, HW'(i), 0, 1); commit();
            drive(0, 1, HW'(i + 8), 0, 1); commit();
            drive(0, 0, '0, 0, 1); commit();
            drive(0, 0, '0, 0, 0);
            total++; if (bus2.frame_cnt !== 2'(seq[i])) begin bad++; $display("FAIL wrap_cnt[%0d] got=%0d want=%0d", i, bus2.frame_cnt, seq[i]); end
            commit();
        end
    endtask

    task automatic test_random();
        logic r;
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(99) == 0);
            drive(r, ($urandom_range(99) < 70), HW'($urandom), ($urandom_range(99) < 15),
                  ($urandom_range(99) < 60));
            total++; if (bus.in_ready !== exp_ready) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%b want=%b", c, bus.in_ready, exp_ready); end
            total++; if (bus.load !== exp_load) begin bad++; $display("FAIL rnd_load[%0d] got=%b want=%b", c, bus.load, exp_load); end
            total++; if (bus.inba !== {d_d, d_d}) begin bad++; $display("FAIL rnd_inba[%0d] got=%h want=%h", c, bus.inba, {d_d, d_d}); end
            total++; if (bus.out_valid !== m_full || bus2.out_valid !== m_full) begin bad++; $display("FAIL rnd_out_valid[%0d] got=%b want=%b", c, bus.out_valid, m_full); end
            total++; if (bus.busy !== (m_lo || m_full)) begin bad++; $display("FAIL rnd_busy[%0d] got=%b want=%b", c, bus.busy, m_lo || m_full); end
            total++; if (bus.frame_cnt !== 8'(m_cnt) || bus2.frame_cnt !== 2'(m_cnt)) begin bad++; $display("FAIL rnd_frame_cnt[%0d] got=%0d/%0d want=%0d", c, bus.frame_cnt, bus2.frame_cnt, m_cnt); end
            if (m_full) begin
                total++; if (y !== {m_y_hi, m_y_lo}) begin bad++; $display("FAIL rnd_y[%0d] got=%h want=%h", c, y, {m_y_hi, m_y_lo}); end
            end
            commit();
        end
    endtask

    initial begin
        total = 0; bad = 0;
        m_lo = 1'b0; m_full = 1'b0; m_cnt = 0; m_y_lo = '0; m_y_hi = '0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
